wb_port_scheduler: RTL

- Schedules the single register-file write port between three producers: the in-order writeback stage, the multi-cycle multiplier and the float unit.
- Holds multi-cycle results in one-entry buffers.
- Keeps a per-register scoreboard so decode stalls on registers that still await a multiplier or float result.
- Sits between the writeback pipeline register, the multi-cycle units and the register file write port.

---
 rtl/wb_sched_pkg.sv | 25 ++
 rtl/wb_port_scheduler_if.sv | 54 +++++
 rtl/wb_hold_buf.sv | 59 +++++
 rtl/wb_port_scheduler.sv | 121 ++++++++++++
 4 files changed

// File: rtl/wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_sched_pkg
// Description : Shared types for the write-port scheduler: register count,
//               port source encoding and round-robin pointer values.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_sched_pkg;

    localparam int NREG = 16;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MUL  = 2'd2,
        SRC_FP   = 2'd3
    } src_e;

    typedef enum logic {
        RR_MUL = 1'b0,
        RR_FP  = 1'b1
    } rr_e;

endpackage
`default_nettype wire

// File: rtl/wb_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_scheduler_if
// Description : Bus bundle between the scheduler and its producers/consumers.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_scheduler_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          pipe_we;
    logic [AW-1:0] pipe_wa;
    logic [DW-1:0] pipe_wd;
    logic          mul_valid;
    logic [AW-1:0] mul_wa;
    logic [DW-1:0] mul_wd;
    logic          mul_ready;
    logic          fp_valid;
    logic [AW-1:0] fp_wa;
    logic [DW-1:0] fp_wd;
    logic          fp_ready;
    logic          issue_mul;
    logic          issue_fp;
    logic [AW-1:0] issue_wa;
    logic [AW-1:0] rd_a1;
    logic [AW-1:0] rd_a2;
    logic [AW-1:0] rd_a3;
    logic          hazard_stall;
    logic          wb_stall;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        output mul_valid, mul_wa, mul_wd,
        output fp_valid, fp_wa, fp_wd,
        output issue_mul, issue_fp, issue_wa,
        output rd_a1, rd_a2, rd_a3,
        input  mul_ready, fp_ready, hazard_stall, wb_stall,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        input  mul_valid, mul_wa, mul_wd,
        input  fp_valid, fp_wa, fp_wd,
        input  issue_mul, issue_fp, issue_wa,
        input  rd_a1, rd_a2, rd_a3,
        output mul_ready, fp_ready, hazard_stall, wb_stall,
        output rf_we, rf_wa, rf_wd
    );
endinterface
`default_nettype wire

// File: rtl/wb_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_hold_buf
// Description : One-entry valid/ready holding register for a multi-cycle result.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hold_buf #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    input  wire logic          in_valid_i,
    input  wire logic [AW-1:0] in_wa_i,
    input  wire logic [DW-1:0] in_wd_i,
    output logic               in_ready_o,
    input  wire logic          drain_i,
    output logic               valid_o,
    output logic [AW-1:0]      wa_o,
    output logic [DW-1:0]      wd_o
);
    logic          valid_q, valid_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;

    // Ready is derived from the registered valid only, so a drain cycle never
    // accepts a refill; the next entry lands one edge later at the earliest.
    assign in_ready_o = ~valid_q;

    always_comb begin
        valid_d = valid_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            wa_d    = in_wa_i;
            wd_d    = in_wd_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    assign valid_o = valid_q;
    assign wa_o    = wa_q;
    assign wd_o    = wd_q;
endmodule
`default_nettype wire

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_scheduler
// Description : Arbitrates the register-file write port between writeback,
//               multiplier and float unit; tracks pending multi-cycle dests.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_scheduler
    import wb_sched_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 4,
    parameter int STARVE_MAX = 4
) (
    input  wire logic         CLK,
    input  wire logic         RESETn,
    wb_port_scheduler_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic          mul_v, fp_v;
    logic [AW-1:0] mul_bwa, fp_bwa;
    logic [DW-1:0] mul_bwd, fp_bwd;
    logic          mul_drain, fp_drain;
    src_e          src;
    logic          buf_grant, contended;
    rr_e           rr_q, rr_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   starve_q, starve_d;

    wb_hold_buf #(.DW(DW), .AW(AW)) u_mul_buf (
        .clk_i      (CLK),
        .rst_ni     (RESETn),
        .in_valid_i (bus.mul_valid),
        .in_wa_i    (bus.mul_wa),
        .in_wd_i    (bus.mul_wd),
        .in_ready_o (bus.mul_ready),
        .drain_i    (mul_drain),
        .valid_o    (mul_v),
        .wa_o       (mul_bwa),
        .wd_o       (mul_bwd)
    );

    wb_hold_buf #(.DW(DW), .AW(AW)) u_fp_buf (
        .clk_i      (CLK),
        .rst_ni     (RESETn),
        .in_valid_i (bus.fp_valid),
        .in_wa_i    (bus.fp_wa),
        .in_wd_i    (bus.fp_wd),
        .in_ready_o (bus.fp_ready),
        .drain_i    (fp_drain),
        .valid_o    (fp_v),
        .wa_o       (fp_bwa),
        .wd_o       (fp_bwd)
    );

    always_comb begin
        src = SRC_NONE;
        if (bus.pipe_we)
            src = SRC_PIPE;
        else if (mul_v && fp_v)
            src = (rr_q == RR_MUL) ? SRC_MUL : SRC_FP;
        else if (mul_v)
            src = SRC_MUL;
        else if (fp_v)
            src = SRC_FP;
    end

    always_comb begin
        bus.rf_we = 1'b1;
        bus.rf_wa = '0;
        bus.rf_wd = '0;
        case (src)
            SRC_PIPE: begin bus.rf_wa = bus.pipe_wa; bus.rf_wd = bus.pipe_wd; end
            SRC_MUL:  begin bus.rf_wa = mul_bwa;     bus.rf_wd = mul_bwd;     end
            SRC_FP:   begin bus.rf_wa = fp_bwa;      bus.rf_wd = fp_bwd;      end
            default:  bus.rf_we = 1'b0;
        endcase
    end

    assign mul_drain = (src == SRC_MUL);
    assign fp_drain  = (src == SRC_FP);
    assign buf_grant = mul_drain | fp_drain;
    // Only a grant decided by the pointer moves it, so the loser of one
    // collision is guaranteed to win the next one.
    assign contended = ~bus.pipe_we & mul_v & fp_v;
    assign rr_d      = contended ? ((rr_q == RR_MUL) ? RR_FP : RR_MUL) : rr_q;

    always_comb begin
        busy_d = busy_q;
        if (buf_grant)
            busy_d[bus.rf_wa] = 1'b0;
        if ((bus.issue_mul || bus.issue_fp) && (bus.issue_wa != AW'(NREG - 1)))
            busy_d[bus.issue_wa] = 1'b1;
        busy_d[NREG-1] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (buf_grant || !(mul_v || fp_v))
            starve_d = '0;
        else if (bus.pipe_we && (starve_q != CW'(STARVE_MAX)))
            starve_d = starve_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rr_q     <= RR_MUL;
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    assign bus.hazard_stall = busy_q[bus.rd_a1] | busy_q[bus.rd_a2] | busy_q[bus.rd_a3];
    assign bus.wb_stall     = (starve_q == CW'(STARVE_MAX));
endmodule
`default_nettype wire
